// File: rtl/mac_array_acc.sv
// Multi-lane multiply-accumulate for the conv datapath.
// Each beat multiplies LANES ifmap/weight pairs, an adder tree sums the products,
// and the sum accumulates across a packet closed by lastdata. The pipeline has two
// stages: products into p1, then adder tree plus accumulate into the output register.
module mac_array_acc #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    signed_mode,
  input  logic                    sat_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] ifmap,
  input  logic [LANES*DATA_W-1:0] weights,
  input  logic                    lastdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        accumulation,
  output logic                    overflow,
  output logic [15:0]             out_count
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Stage 1 operands and products
  logic [PROD_W-1:0] ext_a [LANES];
  logic [PROD_W-1:0] ext_b [LANES];
  logic [PROD_W-1:0] prod  [LANES];

  // Stage 1 registers
  logic              p1_valid;
  logic              p1_last;
  logic              p1_signed;
  logic              p1_sat;
  logic [PROD_W-1:0] p1_prod [LANES];

  // Stage 2 datapath
  logic [ACC_W-1:0]  lane_ext [LANES];
  logic [ACC_W-1:0]  tree_sum;
  logic [ACC_W:0]    usum;
  logic [ACC_W-1:0]  nsum;
  logic              wrap;
  logic              s_oor;
  logic              u_oor;
  logic              clamp;
  logic [OUT_W-1:0]  result;

  // Packet state
  logic [ACC_W-1:0]  acc;
  logic              sticky;
  logic [15:0]       cnt;
  logic [15:0]       cnt_inc;

  // Handshake
  logic              adv;
  logic              accept;

  // Stage-2 advance stalls only when a finished result cannot be handed over
  always_comb begin
    adv      = p1_valid && !(p1_last && out_valid && !out_ready);
    in_ready = !p1_valid || adv;
    accept   = in_valid && in_ready;
  end

  // Per-lane products; operands are extended to full product width first so the
  // low PROD_W bits of the product are correct in either arithmetic mode
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      ext_a[i] = {{DATA_W{signed_mode & ifmap[i*DATA_W + DATA_W - 1]}},
                  ifmap[i*DATA_W +: DATA_W]};
      ext_b[i] = {{DATA_W{signed_mode & weights[i*DATA_W + DATA_W - 1]}},
                  weights[i*DATA_W +: DATA_W]};
      prod[i]  = ext_a[i] * ext_b[i];
    end
  end

  // Stage 1 register: capture products and per-beat controls on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_valid  <= 1'b0;
      p1_last   <= 1'b0;
      p1_signed <= 1'b0;
      p1_sat    <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) p1_prod[i] <= '0;
    end else if (accept) begin
      p1_valid  <= 1'b1;
      p1_last   <= lastdata;
      p1_signed <= signed_mode;
      p1_sat    <= sat_en;
      for (int unsigned i = 0; i < LANES; i++) p1_prod[i] <= prod[i];
    end else if (adv) begin
      p1_valid  <= 1'b0;
    end
  end

  // Adder tree over extended products, accumulate and wrap detection
  always_comb begin
    tree_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_ext[i] = {ACC_W{p1_signed & p1_prod[i][PROD_W-1]}};
      lane_ext[i][PROD_W-1:0] = p1_prod[i];
      tree_sum = tree_sum + lane_ext[i];
    end
    usum = {1'b0, acc} + {1'b0, tree_sum};
    nsum = usum[ACC_W-1:0];
    if (p1_signed)
      wrap = (acc[ACC_W-1] == tree_sum[ACC_W-1]) && (nsum[ACC_W-1] != acc[ACC_W-1]);
    else
      wrap = usum[ACC_W];
  end

  // Range checks against the OUT_W result width; none possible when widths match
  generate
    if (OUT_W == ACC_W) begin : g_no_clamp
      always_comb begin
        s_oor = 1'b0;
        u_oor = 1'b0;
      end
    end else begin : g_clamp
      always_comb begin
        s_oor = !((&nsum[ACC_W-1:OUT_W-1]) || !(|nsum[ACC_W-1:OUT_W-1]));
        u_oor = |nsum[ACC_W-1:OUT_W];
      end
    end
  endgenerate

  // Result selection: clamp to the mode's OUT_W range when enabled, else truncate
  always_comb begin
    result = nsum[OUT_W-1:0];
    clamp  = 1'b0;
    if (p1_sat) begin
      if (p1_signed && s_oor) begin
        clamp  = 1'b1;
        result = nsum[ACC_W-1] ? SMIN : SMAX;
      end else if (!p1_signed && u_oor) begin
        clamp  = 1'b1;
        result = '1;
      end
    end
  end

  // Saturating beat counter increment
  always_comb begin
    cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  end

  // Packet accumulator, sticky wrap flag and beat count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (adv) begin
      if (p1_last) begin
        acc    <= '0;
        sticky <= 1'b0;
        cnt    <= '0;
      end else begin
        acc    <= nsum;
        sticky <= sticky | wrap;
        cnt    <= cnt_inc;
      end
    end
  end

  // Output register: load on the closing beat, otherwise clear once consumed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      accumulation <= '0;
      overflow     <= 1'b0;
      out_count    <= '0;
    end else if (adv && p1_last) begin
      out_valid    <= 1'b1;
      accumulation <= result;
      overflow     <= sticky | wrap | clamp;
      out_count    <= cnt_inc;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
      accumulation <= '0;
      overflow     <= 1'b0;
      out_count    <= '0;
    end
  end

endmodule

// File: tb/tb_mac_array_acc.sv
// Self-checking bench for mac_array_acc with a packet-level arithmetic model.
module tb_mac_array_acc;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 32;
  localparam int VW     = LANES * DATA_W;

  localparam longint TWO39 = 64'sh0000_0080_0000_0000;
  localparam longint TWO40 = 64'sh0000_0100_0000_0000;
  localparam longint SMAX32 = 64'sd2147483647;
  localparam longint SMIN32 = -64'sd2147483648;
  localparam longint UMAX32 = 64'sd4294967295;

  logic clk = 1'b0;
  logic reset;
  logic signed_mode, sat_en, in_valid, lastdata, out_ready;
  logic in_ready, out_valid, overflow;
  logic [VW-1:0] ifmap, weights;
  logic [OUT_W-1:0] accumulation;
  logic [15:0] out_count;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  typedef struct {
    longint acc;
    bit     ovf;
    int     cnt;
    int     cyc;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  longint m_acc;
  bit     m_ovf;
  int     m_cnt;

  mac_array_acc #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .signed_mode(signed_mode), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready), .ifmap(ifmap), .weights(weights),
    .lastdata(lastdata), .out_valid(out_valid), .out_ready(out_ready),
    .accumulation(accumulation), .overflow(overflow), .out_count(out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: forced or random ready, applied 1 time unit after the falling edge
  always @(negedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor and reference model: observes handshakes, computes packet results exactly
  always @(negedge clk) begin : mon
    res_t r;
    longint tree, av, s, nv, sv;
    bit wrap, clamp, sm;
    #3;
    if (!reset) begin
      m_acc = 0; m_ovf = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        r.acc = longint'(accumulation);
        r.ovf = overflow;
        r.cnt = int'(out_count);
        r.cyc = cyc;
        obs_q.push_back(r);
      end
      if (in_valid && in_ready) begin
        sm = signed_mode;
        tree = 0;
        for (int i = 0; i < LANES; i++) begin
          if (sm)
            tree += longint'($signed(ifmap[i*DATA_W +: DATA_W])) *
                    longint'($signed(weights[i*DATA_W +: DATA_W]));
          else
            tree += longint'(ifmap[i*DATA_W +: DATA_W]) *
                    longint'(weights[i*DATA_W +: DATA_W]);
        end
        av = (sm && m_acc >= TWO39) ? m_acc - TWO40 : m_acc;
        s = av + tree;
        wrap = sm ? (s >= TWO39 || s < -TWO39) : (s >= TWO40);
        nv = s & (TWO40 - 1);
        if (lastdata) begin
          sv = (nv >= TWO39) ? nv - TWO40 : nv;
          clamp = 1'b0;
          r.acc = nv & UMAX32;
          if (sat_en) begin
            if (sm) begin
              if (sv > SMAX32) begin r.acc = SMAX32; clamp = 1'b1; end
              else if (sv < SMIN32) begin r.acc = 64'h8000_0000; clamp = 1'b1; end
            end else if (nv > UMAX32) begin
              r.acc = UMAX32; clamp = 1'b1;
            end
          end
          r.ovf = m_ovf | wrap | clamp;
          r.cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
          r.cyc = cyc;
          exp_q.push_back(r);
          m_acc = 0; m_ovf = 0; m_cnt = 0;
        end else begin
          m_acc = nv;
          m_ovf = m_ovf | wrap;
          m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] fill(input logic [DATA_W-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 5))
        0: v[i*DATA_W +: DATA_W] = 16'h7FFF;
        1: v[i*DATA_W +: DATA_W] = 16'h8000;
        2: v[i*DATA_W +: DATA_W] = 16'hFFFF;
        default: v[i*DATA_W +: DATA_W] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; lastdata = 1'b0; signed_mode = 1'b0; sat_en = 1'b0;
    ifmap = '0; weights = '0;
  endtask

  // Presents one beat at a falling edge and holds it until accepted (bounded)
  task automatic send_beat(input logic [VW-1:0] f, input logic [VW-1:0] w,
                           input logic sm, input logic sat, input logic last,
                           output int acc_cyc);
    bit ok;
    int n;
    in_valid = 1'b1; ifmap = f; weights = w;
    signed_mode = sm; sat_en = sat; lastdata = last;
    ok = 1'b0; n = 0; acc_cyc = -1;
    do begin
      #2;
      ok = in_ready;
      acc_cyc = cyc;
      @(negedge clk);
      n++;
    end while (!ok && n < 200);
    in_valid = 1'b0; lastdata = 1'b0;
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout: in_ready stayed %0b, expected 1 within 200 cycles", in_ready);
    end
  endtask

  // Bounded wait for n observed results
  task automatic wait_obs(input int n, input int limit);
    int k = 0;
    while (obs_q.size() < n && k < limit) begin @(negedge clk); k++; end
    if (obs_q.size() < n || exp_q.size() < n) begin
      compared++; mismatched++;
      $display("FAIL result_timeout: observed %0d expected-queue %0d, required %0d", obs_q.size(), exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    int c;
    res_t r, e;
    #2;
    compared++;
    if ({out_valid, accumulation, overflow, out_count} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%0b a=%0h o=%0b c=%0d, required all 0", out_valid, accumulation, overflow, out_count);
    end
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    @(negedge clk); reset = 1'b1; @(negedge clk);
    send_beat(fill(16'd7), fill(16'd7), 1'b0, 1'b0, 1'b0, c);
    send_beat(fill(16'd7), fill(16'd7), 1'b0, 1'b0, 1'b0, c);
    reset = 1'b0;
    #2;
    compared++;
    if ({out_valid, accumulation, overflow, out_count} !== '0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL midpkt_reset: got v=%0b a=%0h o=%0b c=%0d r=%0b, required 0/0/0/0/1", out_valid, accumulation, overflow, out_count, in_ready);
    end
    @(negedge clk); reset = 1'b1; @(negedge clk);
    send_beat(fill(16'd1), fill(16'd1), 1'b0, 1'b0, 1'b1, c);
    wait_obs(1, 20);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (r.acc !== 64'd4 || r.cnt !== 1 || r.ovf !== 1'b0) begin
        mismatched++;
        $display("FAIL post_reset_pkt: got a=%0h c=%0d o=%0b, required a=4 c=1 o=0", r.acc, r.cnt, r.ovf);
      end
      compared++;
      if (r.acc !== e.acc) begin mismatched++; $display("FAIL post_reset_model: got %0h model %0h", r.acc, e.acc); end
    end
  endtask

  task automatic test_unsigned_basic();
    int c;
    res_t r, e;
    for (int b = 0; b < 3; b++)
      send_beat(fill(16'd2), fill(16'd3), 1'b0, 1'b0, b == 2, c);
    wait_obs(1, 20);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (r.acc !== 64'd72 || r.cnt !== 3 || r.ovf !== 1'b0) begin
        mismatched++;
        $display("FAIL unsigned_basic: got a=%0d c=%0d o=%0b, required a=72 c=3 o=0", r.acc, r.cnt, r.ovf);
      end
      compared++;
      if (r.cyc - c !== 2) begin
        mismatched++;
        $display("FAIL latency: got %0d cycles, required 2", r.cyc - c);
      end
      compared++;
      if (r.acc !== e.acc || r.cnt !== e.cnt) begin mismatched++; $display("FAIL unsigned_model: got %0h model %0h", r.acc, e.acc); end
    end
  endtask

  task automatic test_signed();
    int c;
    logic [VW-1:0] f;
    res_t r, e;
    f = {16'sd4, -16'sd3, 16'sd2, -16'sd1};
    send_beat(f, fill(16'd5), 1'b1, 1'b0, 1'b1, c);
    wait_obs(1, 20);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (r.acc !== 64'h0000_000A || r.cnt !== 1 || r.ovf !== 1'b0 || r.acc !== e.acc) begin
        mismatched++;
        $display("FAIL signed_single: got a=%0h c=%0d o=%0b, required a=a c=1 o=0", r.acc, r.cnt, r.ovf);
      end
    end
  endtask

  task automatic test_saturation();
    int c;
    res_t r, e;
    for (int s = 1; s >= 0; s--) begin
      send_beat(fill(16'h7FFF), fill(16'h7FFF), 1'b1, 1'(s), 1'b0, c);
      send_beat(fill(16'h7FFF), fill(16'h7FFF), 1'b1, 1'(s), 1'b1, c);
      wait_obs(1, 20);
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        r = obs_q.pop_front(); e = exp_q.pop_front();
        compared++;
        if (s == 1 && (r.acc !== 64'h7FFF_FFFF || r.ovf !== 1'b1 || r.cnt !== 2)) begin
          mismatched++;
          $display("FAIL sat_on: got a=%0h o=%0b c=%0d, required a=7fffffff o=1 c=2", r.acc, r.ovf, r.cnt);
        end else if (s == 0 && (r.acc !== 64'hFFF8_0008 || r.ovf !== 1'b0 || r.cnt !== 2)) begin
          mismatched++;
          $display("FAIL sat_off: got a=%0h o=%0b c=%0d, required a=fff80008 o=0 c=2", r.acc, r.ovf, r.cnt);
        end
        compared++;
        if (r.acc !== e.acc || r.ovf !== e.ovf) begin mismatched++; $display("FAIL sat_model: got %0h/%0b model %0h/%0b", r.acc, r.ovf, e.acc, e.ovf); end
      end
    end
  endtask

  task automatic test_wrap();
    int c;
    res_t r, e;
    for (int b = 0; b < 70; b++)
      send_beat(fill(16'hFFFF), fill(16'hFFFF), 1'b0, 1'b0, b == 69, c);
    wait_obs(1, 20);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (r.ovf !== 1'b1 || r.cnt !== 70 || r.acc !== e.acc) begin
        mismatched++;
        $display("FAIL acc_wrap: got a=%0h o=%0b c=%0d, required a=%0h o=1 c=70", r.acc, r.ovf, r.cnt, e.acc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    res_t r0, r1, r2;
    ready_force = 1'b0;
    send_beat(fill(16'd1), fill(16'd1), 1'b0, 1'b0, 1'b1, c);
    send_beat(fill(16'd2), fill(16'd1), 1'b0, 1'b0, 1'b1, c);
    in_valid = 1'b1; ifmap = fill(16'd3); weights = fill(16'd1);
    signed_mode = 1'b0; sat_en = 1'b0; lastdata = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      compared++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || accumulation !== 32'd4 || out_count !== 16'd1) begin
        mismatched++;
        $display("FAIL backpressure_hold: cycle %0d r=%0b v=%0b a=%0h c=%0d, required r=0 v=1 a=4 c=1", k, in_ready, out_valid, accumulation, out_count);
      end
      @(negedge clk);
    end
    ready_force = 1'b1;
    #2;
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL backpressure_release: in_ready got %0b required 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; lastdata = 1'b0;
    wait_obs(3, 20);
    if (obs_q.size() >= 3 && exp_q.size() >= 3) begin
      r0 = obs_q.pop_front(); r1 = obs_q.pop_front(); r2 = obs_q.pop_front();
      void'(exp_q.pop_front()); void'(exp_q.pop_front()); void'(exp_q.pop_front());
      compared++;
      if (r0.acc !== 64'd4 || r1.acc !== 64'd8 || r2.acc !== 64'd12) begin
        mismatched++;
        $display("FAIL b2b_order: got %0d,%0d,%0d required 4,8,12", r0.acc, r1.acc, r2.acc);
      end
      compared++;
      if (r1.cyc - r0.cyc !== 1) begin
        mismatched++;
        $display("FAIL b2b_consecutive: gap got %0d required 1", r1.cyc - r0.cyc);
      end
    end
  endtask

  task automatic test_streaming();
    int c, len;
    logic sat, sm;
    res_t r, e;
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 4);
      sat = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        sm = 1'($urandom_range(0, 1));
        send_beat(rnd_vec(), rnd_vec(), sm, sat, b == len - 1, c);
      end
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    wait_obs(100, 500);
    compared++;
    if (obs_q.size() !== 100 || exp_q.size() !== 100) begin
      mismatched++;
      $display("FAIL stream_count: observed %0d model %0d, required 100", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (r.acc !== e.acc || r.ovf !== e.ovf || r.cnt !== e.cnt) begin
        mismatched++;
        $display("FAIL stream_result: got a=%0h o=%0b c=%0d, required a=%0h o=%0b c=%0d", r.acc, r.ovf, r.cnt, e.acc, e.ovf, e.cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_saturation();
    test_wrap();
    test_back_to_back();
    test_streaming();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
